// File: rtl/alu_exec_stage_pkg.sv
// ALU control encodings and shared execute-stage types.
// Single source of SIG_ALU_* codes for decode and execute.
package alu_exec_stage_pkg;

  localparam int CTRL_W = 5;
  localparam int DW     = 32;

  localparam logic [CTRL_W-1:0] SIG_ALU_AND  = 5'd0;
  localparam logic [CTRL_W-1:0] SIG_ALU_OR   = 5'd1;
  localparam logic [CTRL_W-1:0] SIG_ALU_XOR  = 5'd2;
  localparam logic [CTRL_W-1:0] SIG_ALU_NOR  = 5'd3;
  localparam logic [CTRL_W-1:0] SIG_ALU_SLL  = 5'd4;
  localparam logic [CTRL_W-1:0] SIG_ALU_SRL  = 5'd5;
  localparam logic [CTRL_W-1:0] SIG_ALU_SRA  = 5'd6;
  localparam logic [CTRL_W-1:0] SIG_ALU_SLLV = 5'd7;
  localparam logic [CTRL_W-1:0] SIG_ALU_SRLV = 5'd8;
  localparam logic [CTRL_W-1:0] SIG_ALU_SRAV = 5'd9;
  localparam logic [CTRL_W-1:0] SIG_ALU_LUI  = 5'd10;
  localparam logic [CTRL_W-1:0] SIG_ALU_FAIL = 5'd31;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL2 = 2'd2
  } state_e;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          illegal;
  } entry_t;

endpackage

// File: rtl/alu_logic_shift.sv
// Combinational logic/shift/LUI unit driven by alucontrol.
// Kept standalone so the forwarding path can reuse it.
module alu_logic_shift
  import alu_exec_stage_pkg::*;
(
  input  logic [CTRL_W-1:0] alucontrol,
  input  logic [DW-1:0]     srca,
  input  logic [DW-1:0]     srcb,
  input  logic [4:0]        sa,
  output logic [DW-1:0]     result,
  output logic              illegal
);

  logic [4:0] vsa;
  assign vsa = srca[4:0];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    unique case (alucontrol)
      SIG_ALU_AND:  result = srca & srcb;
      SIG_ALU_OR:   result = srca | srcb;
      SIG_ALU_XOR:  result = srca ^ srcb;
      SIG_ALU_NOR:  result = ~(srca | srcb);
      SIG_ALU_SLL:  result = srcb << sa;
      SIG_ALU_SRL:  result = srcb >> sa;
      SIG_ALU_SRA:  result = $signed(srcb) >>> sa;
      SIG_ALU_SLLV: result = srcb << vsa;
      SIG_ALU_SRLV: result = srcb >> vsa;
      SIG_ALU_SRAV: result = $signed(srcb) >>> vsa;
      SIG_ALU_LUI:  result = {srcb[15:0], {(DW-16){1'b0}}};
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: computes at accept time and queues results
// in a 2-entry skid buffer so in_ready is purely registered.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alucontrol,
  input  logic [DW-1:0]     srca,
  input  logic [DW-1:0]     srcb,
  input  logic [4:0]        sa,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     result,
  output logic              illegal
);

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t new_e;
  logic   accept, emit;

  alu_logic_shift u_alu (
    .alucontrol (alucontrol),
    .srca       (srca),
    .srcb       (srcb),
    .sa         (sa),
    .result     (new_e.result),
    .illegal    (new_e.illegal)
  );

  assign in_ready  = (state_q != ST_FULL2);
  assign out_valid = (state_q != ST_EMPTY);
  assign result    = main_q.result;
  assign illegal   = main_q.illegal;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = new_e;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && !emit) begin
          skid_d  = new_e;
          state_d = ST_FULL2;
        end else if (accept && emit) begin
          main_d  = new_e;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL2: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Redirect: drop everything, outputs keep the last shown value.
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule
